// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle control sequencer for the RV32 datapath. A state
//             machine drives every datapath strobe, waits on a shared
//             mem_ready handshake for fetch and data access, counts retired
//             instructions and halts on an unsupported opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic [31:0]      ins,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic             alu_src,
   output logic [2:0]       op,
   output logic             mem_read,
   output logic             mem_write,
   output logic [1:0]       wb_sel,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] OPC_R    = 7'h33;
   localparam logic [6:0] OPC_ADDI = 7'h13;
   localparam logic [6:0] OPC_LW   = 7'h03;
   localparam logic [6:0] OPC_SW   = 7'h23;
   localparam logic [6:0] OPC_BEQ  = 7'h63;
   localparam logic [6:0] OPC_JAL  = 7'h6F;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t      state;
   state_t      state_nx;
   logic [31:0] ir;
   logic        retire;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [2:0]  r_op;
   logic        r_ok;
   logic        ex_src;
   logic [2:0]  ex_op;
   logic        ir_unused;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];

   // Register fields the sequencer never looks at (register numbers, immediates).
   assign ir_unused = ^{ir[31], ir[29:15], ir[11:7]};

   // R-type funct3/funct7 to ALU op; r_ok clears for unsupported funct3.
   always_comb begin
      r_op = ALU_ADD;
      r_ok = 1'b1;
      case (funct3)
         3'b000:  r_op = ir[30] ? ALU_SUB : ALU_ADD;
         3'b110:  r_op = ALU_OR;
         3'b111:  r_op = ALU_AND;
         3'b010:  r_op = ALU_SLT;
         default: r_ok = 1'b0;
      endcase
   end

   // ALU operand/op selection chosen in EXEC and held through MEM and WB.
   always_comb begin
      ex_src = 1'b0;
      ex_op  = ALU_ADD;
      case (opcode)
         OPC_R:                    ex_op  = r_op;
         OPC_ADDI, OPC_LW, OPC_SW: ex_src = 1'b1;
         OPC_BEQ:                  ex_op  = ALU_SUB;
         default:                  ;
      endcase
   end

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Instruction register, loaded only on a completed fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ir <= 32'd0;
      else if (ir_write) ir <= ins;
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      retired <= '0;
      else if (retire) retired <= retired + CNT_W'(1);
   end

   // Next-state and control-strobe decode.
   always_comb begin
      state_nx  = state;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      reg_write = 1'b0;
      alu_src   = 1'b0;
      op        = ALU_ADD;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      wb_sel    = 2'b00;
      halted    = 1'b0;
      retire    = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) state_nx = S_FETCH;
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OPC_R, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL: state_nx = S_EXEC;
               default:                                           state_nx = S_HALT;
            endcase
         end
         S_EXEC: begin
            alu_src = ex_src;
            op      = ex_op;
            case (opcode)
               OPC_R:            state_nx = r_ok ? S_WB : S_HALT;
               OPC_ADDI:         state_nx = S_WB;
               OPC_LW, OPC_SW:   state_nx = S_MEM;
               OPC_BEQ: begin
                  pc_write = 1'b1;
                  pc_src   = zero ? 2'b01 : 2'b00;
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end
               OPC_JAL: begin
                  reg_write = 1'b1;
                  wb_sel    = 2'b10;
                  pc_write  = 1'b1;
                  pc_src    = 2'b10;
                  retire    = 1'b1;
                  state_nx  = S_FETCH;
               end
               default:          state_nx = S_HALT;
            endcase
         end
         S_MEM: begin
            alu_src = 1'b1;
            op      = ALU_ADD;
            if (opcode == OPC_SW) begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end
            end else begin
               mem_read = 1'b1;
               if (mem_ready) state_nx = S_WB;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = (opcode == OPC_LW) ? 2'b01 : 2'b00;
            alu_src   = ex_src;
            op        = ex_op;
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_nx  = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
